// File: rtl/rf_writeback_buffer.sv
// rf_writeback_buffer: writeback queue directly upstream of the register file
// write port. Two producers (port 0 = ALU, port 1 = load unit) feed a
// program-ordered circular FIFO. The FIFO drains one entry per cycle into an
// always-accepting RF write port. Readers get combinational forwarding of
// pending values.
//
// Handshake: a transfer happens on a port in any cycle where valid & ready are
// both high at the rising edge. The producer must hold addr/data stable while
// valid & !ready. Ready depends only on the registered count, so a pop in the
// same cycle frees no space. in1_ready also accounts for an in0 transfer in
// the same cycle, and in1 is the younger of the two.
//
// Because the head pops every cycle the FIFO is non-empty, occupancy after
// any edge is at most DEPTH-1 whenever count was non-zero before that edge.
module rf_writeback_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int DEPTH      = 4,
  parameter int READ_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_in0_valid,
  output logic                             o_in0_ready,
  input  logic [ADDR_WIDTH-1:0]            i_in0_addr,
  input  logic [DATA_WIDTH-1:0]            i_in0_data,
  input  logic                             i_in1_valid,
  output logic                             o_in1_ready,
  input  logic [ADDR_WIDTH-1:0]            i_in1_addr,
  input  logic [DATA_WIDTH-1:0]            i_in1_data,
  output logic                             o_rf_we,
  output logic [ADDR_WIDTH-1:0]            o_rf_waddr,
  output logic [DATA_WIDTH-1:0]            o_rf_wdata,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] i_fwd_addr,
  output logic [READ_PORTS-1:0]            o_fwd_hit,
  output logic [READ_PORTS*DATA_WIDTH-1:0] o_fwd_data,
  output logic [$clog2(DEPTH):0]           o_count,
  output logic                             o_empty,
  output logic                             o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_in0_acc;
  logic                  w_in1_acc;
  logic                  w_push0;
  logic                  w_push1;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_cnt_plus;
  logic [PTR_W-1:0]      w_tail1;
  logic [CNT_W-1:0]      w_npush;

  // Ready comes from registered occupancy only. A pop in the same cycle is
  // never credited, so an accept can't overflow even at full.
  assign o_in0_ready = (r_count <= LIMIT_C);
  assign w_in0_acc   = i_in0_valid & o_in0_ready;
  assign w_cnt_plus  = r_count + CNT_W'(w_in0_acc);
  assign o_in1_ready = (w_cnt_plus <= LIMIT_C);
  assign w_in1_acc   = i_in1_valid & o_in1_ready;

  // Writes to r0 are consumed by the handshake but never queued.
  assign w_push0 = w_in0_acc & (i_in0_addr != '0);
  assign w_push1 = w_in1_acc & (i_in1_addr != '0);
  assign w_pop   = (r_count != '0);

  // in1 lands right behind in0 when both enqueue; otherwise it takes the tail.
  assign w_tail1 = r_tail + PTR_W'(w_push0);
  assign w_npush = CNT_W'(w_push0) + CNT_W'(w_push1);

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_push0) begin
        r_addr[r_tail] <= i_in0_addr;
        r_data[r_tail] <= i_in0_data;
        r_vld[r_tail]  <= 1'b1;
      end
      if (w_push1) begin
        r_addr[w_tail1] <= i_in1_addr;
        r_data[w_tail1] <= i_in1_data;
        r_vld[w_tail1]  <= 1'b1;
      end
      r_tail  <= r_tail + PTR_W'(w_push0) + PTR_W'(w_push1);
      r_count <= r_count + w_npush - CNT_W'(w_pop);
    end
  end

  // Drain: present the head entry to the RF whenever anything is queued.
  always_comb begin
    o_rf_we    = w_pop;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    if (w_pop) begin
      o_rf_waddr = r_addr[r_head];
      o_rf_wdata = r_data[r_head];
    end
  end

  // Forwarding: walk entries from oldest to youngest so the youngest match
  // overrides. r0 never hits.
  always_comb begin
    o_fwd_hit  = '0;
    o_fwd_data = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i_fwd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
            r_vld[r_head + PTR_W'(i)] &&
            (r_addr[r_head + PTR_W'(i)] == i_fwd_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          o_fwd_hit[k]                         = 1'b1;
          o_fwd_data[k*DATA_WIDTH +: DATA_WIDTH] = r_data[r_head + PTR_W'(i)];
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_C);

endmodule
